// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
// MISALIGN_TRAP_EN adds the FAULT state for misaligned redirect targets.
package fetch_pkg;

  localparam int unsigned INSTR_BYTES = 4;
  localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;

`ifdef MISALIGN_TRAP_EN
  typedef enum logic [1:0] {FETCH, WAIT, HOLD, FAULT} fetch_state_t;
`else
  typedef enum logic [1:0] {FETCH, WAIT, HOLD} fetch_state_t;
`endif

  function automatic logic misaligned(input logic [1:0] lsb);
    return lsb != 2'b00;
  endfunction

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter with next-pc selection: sequential step or word-aligned redirect target.
module fetch_pc_reg
  import fetch_pkg::*;
#(
  parameter int unsigned        ADDR_W   = 32,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              advance,
  input  logic              take,
  input  logic [ADDR_W-1:0] target,
  output logic [ADDR_W-1:0] pc
);

  logic [ADDR_W-1:0] next_pc;

  // Targets are always word-aligned here; misalignment trapping is decided by the FSM.
  always_comb begin
    next_pc = pc + ADDR_W'(INSTR_BYTES);
    if (take)
      next_pc = target & ~ADDR_W'(INSTR_BYTES - 1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      pc <= RESET_PC;
    else if (advance)
      pc <= next_pc;
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch FSM and single-entry instruction buffer; one imem request outstanding at a time.
// Build option: MISALIGN_TRAP_EN enables the sticky misaligned-redirect FAULT state.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned        ADDR_W   = 32,
  parameter logic [ADDR_W-1:0]  RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_rvalid,
  input  logic [31:0]       imem_rdata,
  output logic [31:0]       instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  input  logic              PCsrc,
  input  logic [ADDR_W-1:0] pc_target,
  output logic              fetch_fault
);

  fetch_state_t      state;
  logic [ADDR_W-1:0] pc;
  logic              handshake;

  assign handshake = instr_valid & instr_ready;
  assign imem_addr = pc;

  fetch_pc_reg #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk     (clk),
    .rst_n   (rst_n),
    .advance (handshake),
    .take    (PCsrc),
    .target  (pc_target),
    .pc      (pc)
  );

`ifndef MISALIGN_TRAP_EN
  assign fetch_fault = 1'b0;
`endif

  // imem_req is raised on entry to FETCH (from HOLD) so the next request lands one cycle
  // after the handshake; out of reset FETCH spends one extra cycle raising it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= FETCH;
      imem_req    <= 1'b0;
      instr       <= NOP_INSTR;
      instr_pc    <= RESET_PC;
      instr_valid <= 1'b0;
`ifdef MISALIGN_TRAP_EN
      fetch_fault <= 1'b0;
`endif
    end else begin
      case (state)
        FETCH: begin
          if (imem_req) begin
            imem_req <= 1'b0;
            state    <= WAIT;
          end else begin
            imem_req <= 1'b1;
          end
        end
        WAIT: begin
          if (imem_rvalid) begin
            instr       <= imem_rdata;
            instr_pc    <= pc;
            instr_valid <= 1'b1;
            state       <= HOLD;
          end
        end
        HOLD: begin
          if (handshake) begin
            instr_valid <= 1'b0;
`ifdef MISALIGN_TRAP_EN
            if (PCsrc && misaligned(pc_target[1:0])) begin
              state       <= FAULT;
              fetch_fault <= 1'b1;
            end else begin
              state    <= FETCH;
              imem_req <= 1'b1;
            end
`else
            state    <= FETCH;
            imem_req <= 1'b1;
`endif
          end
        end
`ifdef MISALIGN_TRAP_EN
        FAULT: state <= FAULT;
`endif
        default: state <= FETCH;
      endcase
    end
  end

  rvalid_only_in_wait: assert property (@(posedge clk) disable iff (!rst_n)
    imem_rvalid |-> state == WAIT)
    else $error("imem_rvalid asserted outside WAIT");

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: reset, sequential fetch, stalls, redirects, wrap, misalignment.
module tb_instr_fetch_unit;
  import fetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req, instr_valid, fetch_fault;
  logic [31:0] imem_addr, instr, instr_pc;
  logic        rvalid, ready, pcsrc;
  logic [31:0] rdata, pc_target;

  logic        wrap_req, wrap_valid, wrap_fault;
  logic [31:0] wrap_addr, wrap_instr, wrap_pc;

  int checks = 0;
  int errors = 0;
  logic [31:0] last_instr;

  always #5 clk = ~clk;

  instr_fetch_unit #(.ADDR_W(32), .RESET_PC(32'h0000_0000)) u_dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(rvalid), .imem_rdata(rdata), .instr(instr), .instr_pc(instr_pc),
    .instr_valid(instr_valid), .instr_ready(ready), .PCsrc(pcsrc),
    .pc_target(pc_target), .fetch_fault(fetch_fault)
  );

  // Runs in lockstep with u_dut (same memory timing, never redirected).
  instr_fetch_unit #(.ADDR_W(32), .RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .clk(clk), .rst_n(rst_n), .imem_req(wrap_req), .imem_addr(wrap_addr),
    .imem_rvalid(rvalid), .imem_rdata(rdata), .instr(wrap_instr), .instr_pc(wrap_pc),
    .instr_valid(wrap_valid), .instr_ready(ready), .PCsrc(1'b0),
    .pc_target(32'h0000_0000), .fetch_fault(wrap_fault)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic wait_req();
    for (int k = 0; k < 10; k++) begin
      if (imem_req) break;
      tick();
    end
    chk1("req_after_reset", imem_req, 1'b1);
  endtask

  task automatic respond(input int d, input logic [31:0] data);
    for (int k = 0; k < d; k++) begin
      tick();
      chk1("wait_no_req", imem_req, 1'b0);
      chk1("wait_no_valid", instr_valid, 1'b0);
      chk32("wait_instr_stable", instr, last_instr);
    end
    rvalid = 1'b1;
    rdata  = data;
    tick();
    rvalid = 1'b0;
    rdata  = 32'hDEAD_BEEF;
  endtask

  task automatic fetch_one(input logic [31:0] exp_addr, input logic [31:0] data, input int d);
    chk1("req", imem_req, 1'b1);
    chk32("imem_addr", imem_addr, exp_addr);
    respond(d, data);
    chk1("instr_valid", instr_valid, 1'b1);
    chk32("instr", instr, data);
    chk32("instr_pc", instr_pc, exp_addr);
    last_instr = data;
  endtask

  initial begin
    rst_n = 1'b0; rvalid = 1'b0; rdata = '0; ready = 1'b1;
    pcsrc = 1'b0; pc_target = '0; last_instr = NOP_INSTR;
    tick(); tick();
    chk1("rst_req", imem_req, 1'b0);
    chk1("rst_valid", instr_valid, 1'b0);
    chk32("rst_instr", instr, NOP_INSTR);
    chk32("rst_instr_pc", instr_pc, 32'h0);
    chk1("rst_fault", fetch_fault, 1'b0);
    chk32("rst_wrap_pc", wrap_pc, 32'hFFFF_FFFC);
    rst_n = 1'b1;

    // Sequential fetch at 3-cycle spacing, plus PC wrap on the second instance.
    wait_req();
    chk1("wrap_req0", wrap_req, 1'b1);
    chk32("wrap_addr0", wrap_addr, 32'hFFFF_FFFC);
    fetch_one(32'h0, 32'h0010_0093, 1);
    chk32("wrap_instr_pc0", wrap_pc, 32'hFFFF_FFFC);
    tick();
    chk1("wrap_req1", wrap_req, 1'b1);
    chk32("wrap_addr1", wrap_addr, 32'h0000_0000);
    fetch_one(32'h4, 32'h0020_0113, 1);
    tick();
    fetch_one(32'h8, 32'h0030_0193, 1);
    tick();
    fetch_one(32'hC, 32'h0040_0213, 1);
    tick();

    // Reset asserted mid-WAIT: outputs return to reset values immediately.
    chk1("req_10", imem_req, 1'b1);
    chk32("addr_10", imem_addr, 32'h10);
    tick();
    rst_n = 1'b0;
    #1;
    chk1("midrst_req", imem_req, 1'b0);
    chk1("midrst_valid", instr_valid, 1'b0);
    chk32("midrst_instr", instr, NOP_INSTR);
    chk32("midrst_instr_pc", instr_pc, 32'h0);
    chk1("midrst_fault", fetch_fault, 1'b0);
    last_instr = NOP_INSTR;
    tick();
    rst_n = 1'b1;
    wait_req();
    chk32("wrap_addr_after_rst", wrap_addr, 32'hFFFF_FFFC);
    fetch_one(32'h0, 32'h0000_0517, 1);
    tick();

    // Late response and decode stall; a redirect without handshake is ignored.
    ready = 1'b0;
    fetch_one(32'h4, 32'h00A5_0533, 5);
    for (int k = 0; k < 4; k++) begin
      pcsrc = (k == 1);
      pc_target = 32'h80;
      tick();
      chk1("stall_valid", instr_valid, 1'b1);
      chk32("stall_instr", instr, 32'h00A5_0533);
      chk1("stall_no_req", imem_req, 1'b0);
    end
    pcsrc = 1'b0;
    ready = 1'b1;
    tick();
    fetch_one(32'h8, 32'h0000_0463, 2);

    // Redirect at pc=8, then a self-loop redirect.
    pcsrc = 1'b1; pc_target = 32'h40;
    tick();
    pcsrc = 1'b0;
    fetch_one(32'h40, 32'h0000_006F, 1);
    pcsrc = 1'b1; pc_target = 32'h40;
    tick();
    pcsrc = 1'b0;
    fetch_one(32'h40, 32'h0000_006F, 1);

    // Misaligned redirect target.
    pcsrc = 1'b1; pc_target = 32'h42;
    tick();
    pcsrc = 1'b0;
`ifdef MISALIGN_TRAP_EN
    for (int k = 0; k < 3; k++) begin
      chk1("fault_no_req", imem_req, 1'b0);
      chk1("fault_flag", fetch_fault, 1'b1);
      chk1("fault_no_valid", instr_valid, 1'b0);
      tick();
    end
`else
    chk1("misalign_fault", fetch_fault, 1'b0);
    fetch_one(32'h40, 32'h0000_0013, 1);
    chk1("misalign_fault_after", fetch_fault, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
